// File: rtl/core_mem_responder.sv
// Memory-side responder: edge-detected fetch/data requests share one word array
// through a fixed-latency access FSM; includes a backdoor preload port.
module core_mem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter int unsigned READ_LAT = 2,
  parameter logic [31:0] ERR_WORD = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [31:0]   pc,
  input  logic          ins_read,
  input  logic [31:0]   mar,
  input  logic [31:0]   mdr,
  input  logic          dwen,
  input  logic          mem_read,
  output logic [31:0]   instruction,
  output logic [31:0]   data,
  output logic          ins_valid,
  output logic          data_valid,
  output logic          busy,
  output logic          addr_err,
  input  logic          ld_wen,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] LatInit = CW'(READ_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIWait, StDWait} state_e;

  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  logic          prev_ins_q, prev_mem_q;
  logic          ins_req, mem_req;
  logic          i_pend_q, i_pend_d, i_oor_q, i_oor_d;
  logic [AW-1:0] i_idx_q, i_idx_d;
  logic          d_pend_q, d_pend_d, d_oor_q, d_oor_d, d_wr_q, d_wr_d;
  logic [AW-1:0] d_idx_q, d_idx_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_idx_q, acc_idx_d;
  logic          acc_oor_q, acc_oor_d, acc_wr_q, acc_wr_d;
  logic [31:0]   instruction_q, instruction_d, data_q, data_d;
  logic          ins_valid_q, ins_valid_d, data_valid_q, data_valid_d;
  logic          addr_err_q, addr_err_d;
  logic          unused_addr_bits;

  assign ins_req = en & ins_read & ~prev_ins_q;
  assign mem_req = en & mem_read & ~prev_mem_q;
  assign unused_addr_bits = ^{pc[1:0], mar[1:0]};

  always_comb begin
    i_pend_d      = i_pend_q;
    i_idx_d       = i_idx_q;
    i_oor_d       = i_oor_q;
    d_pend_d      = d_pend_q;
    d_idx_d       = d_idx_q;
    d_oor_d       = d_oor_q;
    d_wr_d        = d_wr_q;
    d_wdata_d     = d_wdata_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_idx_d     = acc_idx_q;
    acc_oor_d     = acc_oor_q;
    acc_wr_d      = acc_wr_q;
    instruction_d = instruction_q;
    data_d        = data_q;
    ins_valid_d   = 1'b0;
    data_valid_d  = 1'b0;
    addr_err_d    = addr_err_q;
    mem_we        = 1'b0;
    mem_widx      = ld_addr;
    mem_wdata     = ld_data;

    unique case (state_q)
      StIdle: begin
        if (i_pend_q) begin
          state_d    = StIWait;
          cnt_d      = LatInit;
          i_pend_d   = 1'b0;
          acc_idx_d  = i_idx_q;
          acc_oor_d  = i_oor_q;
          addr_err_d = addr_err_q | i_oor_q;
        end else if (d_pend_q) begin
          state_d    = StDWait;
          cnt_d      = LatInit;
          d_pend_d   = 1'b0;
          acc_idx_d  = d_idx_q;
          acc_oor_d  = d_oor_q;
          acc_wr_d   = d_wr_q;
          addr_err_d = addr_err_q | d_oor_q;
          // Writes commit on entry so any later access observes them.
          if (d_wr_q && !d_oor_q) begin
            mem_we    = 1'b1;
            mem_widx  = d_idx_q;
            mem_wdata = d_wdata_q;
          end
        end else if (ld_wen && !en) begin
          mem_we = 1'b1;
        end
      end
      StIWait: begin
        if (cnt_q == '0) begin
          state_d       = StIdle;
          instruction_d = acc_oor_q ? ERR_WORD : mem_q[acc_idx_q];
          ins_valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDWait: begin
        if (cnt_q == '0) begin
          state_d      = StIdle;
          data_valid_d = 1'b1;
          if (!acc_wr_q) data_d = acc_oor_q ? 32'h0 : mem_q[acc_idx_q];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh edge wins over the consume above; operands of a pending request are replaced.
    if (ins_req) begin
      i_pend_d = 1'b1;
      i_idx_d  = pc[AW+1:2];
      i_oor_d  = |pc[31:AW+2];
    end
    if (mem_req) begin
      d_pend_d  = 1'b1;
      d_idx_d   = mar[AW+1:2];
      d_oor_d   = |mar[31:AW+2];
      d_wr_d    = dwen;
      d_wdata_d = mdr;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_ins_q    <= 1'b0;
      prev_mem_q    <= 1'b0;
      i_pend_q      <= 1'b0;
      i_idx_q       <= '0;
      i_oor_q       <= 1'b0;
      d_pend_q      <= 1'b0;
      d_idx_q       <= '0;
      d_oor_q       <= 1'b0;
      d_wr_q        <= 1'b0;
      d_wdata_q     <= '0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      acc_idx_q     <= '0;
      acc_oor_q     <= 1'b0;
      acc_wr_q      <= 1'b0;
      instruction_q <= '0;
      data_q        <= '0;
      ins_valid_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      prev_ins_q    <= ins_read;
      prev_mem_q    <= mem_read;
      i_pend_q      <= i_pend_d;
      i_idx_q       <= i_idx_d;
      i_oor_q       <= i_oor_d;
      d_pend_q      <= d_pend_d;
      d_idx_q       <= d_idx_d;
      d_oor_q       <= d_oor_d;
      d_wr_q        <= d_wr_d;
      d_wdata_q     <= d_wdata_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_idx_q     <= acc_idx_d;
      acc_oor_q     <= acc_oor_d;
      acc_wr_q      <= acc_wr_d;
      instruction_q <= instruction_d;
      data_q        <= data_d;
      ins_valid_q   <= ins_valid_d;
      data_valid_q  <= data_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign instruction = instruction_q;
  assign data        = data_q;
  assign ins_valid   = ins_valid_q;
  assign data_valid  = data_valid_q;
  assign addr_err    = addr_err_q;
  assign busy        = i_pend_q | d_pend_q | (state_q != StIdle);

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_core_mem_responder;
  localparam int unsigned READ_LAT = 2;
  localparam logic [31:0] ERR_WORD = 32'h0000_0013;

  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic        ins_read = 1'b0, dwen = 1'b0, mem_read = 1'b0, ld_wen = 1'b0;
  logic [31:0] pc = '0, mar = '0, mdr = '0, ld_data = '0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] instruction, data;
  logic        ins_valid, data_valid, busy, addr_err;

  core_mem_responder #(
    .DEPTH(1024), .AW(10), .READ_LAT(READ_LAT), .ERR_WORD(ERR_WORD)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .pc(pc), .ins_read(ins_read), .mar(mar), .mdr(mdr),
    .dwen(dwen), .mem_read(mem_read), .instruction(instruction), .data(data),
    .ins_valid(ins_valid), .data_valid(data_valid), .busy(busy), .addr_err(addr_err),
    .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int ins_cnt = 0, dat_cnt = 0, ins_t = 0, dat_t = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: one server, fetch first, READ_LAT edges per access, idle edge between.
  logic [31:0] m_mem [1024];
  bit          m_pi = 0, m_pm = 0, m_ipend = 0, m_dpend = 0, m_fly = 0, m_kind = 0;
  bit          m_wr = 0, m_dwen = 0;
  logic [31:0] m_ipc = '0, m_dmar = '0, m_dmdr = '0, m_res = '0;
  logic [31:0] e_instr = '0, e_data = '0;
  bit          e_iv = 0, e_dv = 0, e_err = 0;
  int          m_left = 0;

  task automatic model_step();
    bit ie, de, oor;
    logic [9:0] idx;
    if (!rstn) begin
      m_pi = 0; m_pm = 0; m_ipend = 0; m_dpend = 0; m_fly = 0; m_left = 0;
      e_instr = '0; e_data = '0; e_iv = 0; e_dv = 0; e_err = 0;
      return;
    end
    ie = en && ins_read && !m_pi;
    de = en && mem_read && !m_pm;
    m_pi = ins_read;
    m_pm = mem_read;
    e_iv = 0;
    e_dv = 0;
    if (m_fly) begin
      m_left--;
      if (m_left == 0) begin
        m_fly = 0;
        if (!m_kind) begin
          e_instr = m_res; e_iv = 1;
        end else begin
          if (!m_wr) e_data = m_res;
          e_dv = 1;
        end
      end
    end else if (m_ipend) begin
      m_ipend = 0; m_fly = 1; m_left = READ_LAT; m_kind = 0;
      oor = (m_ipc[31:12] != 0);
      idx = m_ipc[11:2];
      if (oor) e_err = 1;
      m_res = oor ? ERR_WORD : m_mem[idx];
    end else if (m_dpend) begin
      m_dpend = 0; m_fly = 1; m_left = READ_LAT; m_kind = 1; m_wr = m_dwen;
      oor = (m_dmar[31:12] != 0);
      idx = m_dmar[11:2];
      if (oor) e_err = 1;
      if (m_dwen && !oor) m_mem[idx] = m_dmdr;
      m_res = oor ? 32'h0 : m_mem[idx];
    end else if (ld_wen && !en) begin
      m_mem[ld_addr] = ld_data;
    end
    if (ie) begin m_ipend = 1; m_ipc = pc; end
    if (de) begin m_dpend = 1; m_dmar = mar; m_dmdr = mdr; m_dwen = dwen; end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare plus pulse bookkeeping.
  initial forever begin
    @(negedge clk);
    if (ins_valid) begin ins_cnt++; ins_t = cyc; end
    if (data_valid) begin dat_cnt++; dat_t = cyc; end
    if (rstn && chk_on) begin
      chk("ins_valid", 32'(ins_valid), 32'(e_iv));
      chk("data_valid", 32'(data_valid), 32'(e_dv));
      chk("busy", 32'(busy), 32'(m_ipend | m_dpend | m_fly));
      chk("addr_err", 32'(addr_err), 32'(e_err));
      chk("instruction", instruction, e_instr);
      chk("data", data, e_data);
    end
  end

  task automatic wait_iv(input int c0, output int t);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (ins_cnt != c0) begin t = ins_t; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL ins_valid_timeout: got none expected pulse (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_dv(input int c0, output int t);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (dat_cnt != c0) begin t = dat_t; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL data_valid_timeout: got none expected pulse (cycle %0d)", cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_instruction"}, instruction, 32'h0);
    chk({tag, "_data"}, data, 32'h0);
    chk({tag, "_ins_valid"}, 32'(ins_valid), 32'h0);
    chk({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cap, t, t2, c0;
    bit bad;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); #2 rstn = 1'b1; chk_on = 1'b1;

    // Backdoor preload words 0..15 with en low
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_wen = 1'b1; ld_addr = 10'(i);
      ld_data = (i == 5) ? 32'hDEAD_BEEF : 32'hA5A5_0000 + 32'(i);
    end
    @(negedge clk); ld_wen = 1'b0; en = 1'b1;

    // Fetch of preloaded word
    @(negedge clk); pc = 32'h14; ins_read = 1'b1; cap = cyc + 1; c0 = ins_cnt;
    wait_iv(c0, t);
    chk("fetch_latency", 32'(t - cap), 32'd3);
    chk("fetch_word", instruction, 32'hDEAD_BEEF);
    @(negedge clk); ins_read = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("fetch_hold", instruction, 32'hDEAD_BEEF);

    // Write then read back through a misaligned address
    @(negedge clk); mar = 32'h40; mdr = 32'h1234_5678; dwen = 1'b1; mem_read = 1'b1;
    cap = cyc + 1; c0 = dat_cnt;
    wait_dv(c0, t);
    chk("write_latency", 32'(t - cap), 32'd3);
    chk("write_data_held", data, 32'h0);
    @(negedge clk); mem_read = 1'b0; dwen = 1'b0;
    @(negedge clk); mar = 32'h43; mem_read = 1'b1; c0 = dat_cnt;
    wait_dv(c0, t);
    chk("raw_data", data, 32'h1234_5678);
    @(negedge clk); mem_read = 1'b0;

    // Simultaneous edges: fetch first, data 3 cycles later, busy throughout
    @(negedge clk); pc = 32'h14; mar = 32'h14; ins_read = 1'b1; mem_read = 1'b1;
    c0 = dat_cnt; t = -1; t2 = -1; bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (dat_cnt != c0) begin t2 = dat_t; break; end
      if (!busy) bad = 1'b1;
      if (ins_valid) t = cyc;
    end
    chk("sim_order", 32'(t2 - t), 32'd3);
    chk("sim_busy", 32'(bad), 32'h0);
    chk("sim_instr", instruction, 32'hDEAD_BEEF);
    chk("sim_data", data, 32'hDEAD_BEEF);
    @(negedge clk); ins_read = 1'b0; mem_read = 1'b0;

    // Out-of-range fetch and sticky error
    @(negedge clk); pc = 32'h0001_0000; ins_read = 1'b1; c0 = ins_cnt;
    wait_iv(c0, t);
    chk("oor_fetch", instruction, 32'h0000_0013);
    chk("addr_err_set", 32'(addr_err), 32'h1);
    @(negedge clk); ins_read = 1'b0;
    repeat (100) @(negedge clk);
    #1 chk("addr_err_sticky", 32'(addr_err), 32'h1);

    // Out-of-range write must not alias onto word 0
    @(negedge clk); mar = 32'h8000_0000; mdr = 32'hFFFF_FFFF; dwen = 1'b1; mem_read = 1'b1;
    c0 = dat_cnt;
    wait_dv(c0, t);
    @(negedge clk); mem_read = 1'b0; dwen = 1'b0;
    @(negedge clk); mar = 32'h0; mem_read = 1'b1; c0 = dat_cnt;
    wait_dv(c0, t);
    chk("oor_write_dropped", data, 32'hA5A5_0000);
    @(negedge clk); mem_read = 1'b0;

    // Level held high yields one request
    @(negedge clk); pc = 32'h8; ins_read = 1'b1; c0 = ins_cnt;
    repeat (10) @(negedge clk);
    #1 chk("level_hold_once", 32'(ins_cnt - c0), 32'd1);
    chk("level_hold_word", instruction, 32'hA5A5_0002);
    @(negedge clk); ins_read = 1'b0;

    // Edge with en low is dropped
    @(negedge clk); en = 1'b0;
    @(negedge clk); ins_read = 1'b1; c0 = ins_cnt;
    repeat (10) @(negedge clk);
    #1 chk("en_gated", 32'(ins_cnt - c0), 32'd0);
    chk("en_gated_busy", 32'(busy), 32'h0);
    @(negedge clk); ins_read = 1'b0;

    // en dropped mid-access, backdoor attempted while busy
    @(negedge clk); en = 1'b1;
    @(negedge clk); pc = 32'hC; ins_read = 1'b1; c0 = ins_cnt;
    @(negedge clk); en = 1'b0; ins_read = 1'b0;
    ld_wen = 1'b1; ld_addr = 10'd3; ld_data = 32'h0BAD_0BAD;
    @(negedge clk);
    @(negedge clk); ld_wen = 1'b0;
    wait_iv(c0, t);
    chk("en_drop_fetch", instruction, 32'hA5A5_0003);
    @(negedge clk); en = 1'b1; mar = 32'hC; dwen = 1'b0; mem_read = 1'b1; c0 = dat_cnt;
    wait_dv(c0, t);
    chk("ld_busy_ignored", data, 32'hA5A5_0003);
    @(negedge clk); mem_read = 1'b0;

    // Asynchronous reset while a data read is in flight
    @(negedge clk); mar = 32'h14; mem_read = 1'b1; c0 = dat_cnt;
    @(negedge clk);
    @(negedge clk); #2 rstn = 1'b0; mem_read = 1'b0; en = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1; en = 1'b1;
    repeat (10) @(negedge clk);
    #1 chk("no_dv_after_reset", 32'(dat_cnt - c0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
